// File: rtl/yblock_cfg_pkg.sv
// Shared register map, bit positions and sequencer state encoding for the
// yblock configuration loader.
package yblock_cfg_pkg;

  localparam logic [1:0] REG_DATA   = 2'd0;
  localparam logic [1:0] REG_CTRL   = 2'd1;
  localparam logic [1:0] REG_STATUS = 2'd2;

  localparam int CTRL_BLK_RESET_BIT = 0;
  localparam int CTRL_FLUSH_BIT     = 1;

  localparam int ST_BUSY_BIT  = 0;
  localparam int ST_FULL_BIT  = 1;
  localparam int ST_EMPTY_BIT = 2;
  localparam int ST_DONE_BIT  = 3;
  localparam int ST_LEVEL_LSB = 4;
  localparam int ST_ROWS_LSB  = 8;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SETUP = 2'd1;
  localparam logic [1:0] S_PULSE = 2'd2;
  localparam logic [1:0] S_HOLD  = 2'd3;

  function automatic logic [31:0] pack_status(input logic busy, input logic full,
                                               input logic empty, input logic done,
                                               input logic [3:0] level,
                                               input logic [7:0] rows);
    logic [31:0] w;
    w = '0;
    w[ST_BUSY_BIT]            = busy;
    w[ST_FULL_BIT]            = full;
    w[ST_EMPTY_BIT]           = empty;
    w[ST_DONE_BIT]            = done;
    w[ST_LEVEL_LSB +: 4]      = level;
    w[ST_ROWS_LSB +: 8]       = rows;
    return w;
  endfunction

endpackage

// File: rtl/cfg_row_fifo.sv
// Row-word FIFO: head is visible without popping; flush empties it in one cycle.
module cfg_row_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4,
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  input  logic             flush,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      level
);

  localparam logic [AW-1:0] PTR_ONE  = 1;
  localparam logic [AW:0]   CNT_ONE  = 1;
  localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CNT_FULL);
  assign empty   = (count == '0);
  assign level   = count;
  assign head    = mem[rd_ptr];
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/yblock_config_loader.sv
// Wishbone slave that queues configuration rows and strobes them into a
// yblock with a setup / pulse / hold confclk sequence.
module yblock_config_loader
  import yblock_cfg_pkg::*;
#(
  parameter int          BLOCKWIDTH  = 16,
  parameter int          BLOCKHEIGHT = 16,
  parameter int          FIFO_DEPTH  = 4,
  parameter int          SETUP_CYC   = 2,
  parameter int          PULSE_CYC   = 2,
  parameter int          HOLD_CYC    = 2,
  parameter logic [31:0] ADR_BASE    = 32'h3000_0000
) (
  input  logic                  wb_clk_i,
  input  logic                  wb_rst_n,
  input  logic                  wbs_stb_i,
  input  logic                  wbs_cyc_i,
  input  logic                  wbs_we_i,
  input  logic [3:0]            wbs_sel_i,
  input  logic [31:0]           wbs_adr_i,
  input  logic [31:0]           wbs_dat_i,
  output logic                  wbs_ack_o,
  output logic [31:0]           wbs_dat_o,
  output logic [BLOCKWIDTH-1:0] cbitin,
  output logic                  confclk,
  output logic                  blk_reset,
  input  logic [BLOCKWIDTH-1:0] cbitout
);

  localparam int FAW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [7:0] SETUP_INIT = 8'(SETUP_CYC - 1);
  localparam logic [7:0] PULSE_INIT = 8'(PULSE_CYC - 1);
  localparam logic [7:0] HOLD_INIT  = 8'(HOLD_CYC - 1);

  logic [1:0]            state, state_d;
  logic [7:0]            cnt, cnt_d;
  logic                  confclk_d;
  logic [BLOCKWIDTH-1:0] cbitin_d;
  logic [BLOCKWIDTH-1:0] last_out;
  logic [7:0]            rows;
  logic                  pop, row_done;

  logic [BLOCKWIDTH-1:0] fifo_head;
  logic                  fifo_full, fifo_empty;
  logic [FAW:0]          fifo_level;

  logic       wb_valid, data_wr, wb_stall, wb_take, push, ctrl_wr, flush, abort;
  logic [1:0] reg_sel;
  logic [31:0] rd_data;
  logic       busy, done;
  logic       unused_ok;

  // Handshake: an access is valid when cyc & stb & address hit. The slave
  // accepts it (performs the write / captures read data) on the edge that
  // raises ack, so ack is a one-cycle pulse and never repeats back-to-back.
  // A DATA push to a full FIFO is held off (no ack) until space exists.
  assign wb_valid = wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:4] == ADR_BASE[31:4]);
  assign reg_sel  = wbs_adr_i[3:2];
  assign data_wr  = wb_valid & wbs_we_i & (reg_sel == REG_DATA) & (wbs_sel_i[1:0] == 2'b11);
  assign wb_stall = data_wr & fifo_full;
  assign wb_take  = wb_valid & ~wbs_ack_o & ~wb_stall;
  assign push     = wb_take & data_wr;
  assign ctrl_wr  = wb_take & wbs_we_i & (reg_sel == REG_CTRL);
  assign flush    = ctrl_wr & wbs_dat_i[CTRL_FLUSH_BIT];
  assign abort    = ctrl_wr & (wbs_dat_i[CTRL_BLK_RESET_BIT] | wbs_dat_i[CTRL_FLUSH_BIT]);

  assign busy      = (state != S_IDLE);
  assign done      = ({24'd0, rows} >= 32'(BLOCKHEIGHT));
  assign unused_ok = ^{wbs_sel_i[3:2], wbs_adr_i[1:0], wbs_dat_i[31:16]};

  cfg_row_fifo #(
    .WIDTH (BLOCKWIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (wb_clk_i),
    .rst_n (wb_rst_n),
    .push  (push),
    .wdata (wbs_dat_i[BLOCKWIDTH-1:0]),
    .pop   (pop),
    .flush (flush),
    .head  (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  always_comb begin
    state_d   = state;
    cnt_d     = cnt;
    confclk_d = confclk;
    cbitin_d  = cbitin;
    pop       = 1'b0;
    row_done  = 1'b0;
    case (state)
      S_IDLE: begin
        if (!fifo_empty && !blk_reset) begin
          state_d  = S_SETUP;
          cbitin_d = fifo_head;
          cnt_d    = SETUP_INIT;
        end
      end
      S_SETUP: begin
        if (cnt == '0) begin
          state_d   = S_PULSE;
          confclk_d = 1'b1;
          cnt_d     = PULSE_INIT;
        end else begin
          cnt_d = cnt - 8'd1;
        end
      end
      S_PULSE: begin
        if (cnt == '0) begin
          state_d   = S_HOLD;
          confclk_d = 1'b0;
          pop       = 1'b1;
          cnt_d     = HOLD_INIT;
        end else begin
          cnt_d = cnt - 8'd1;
        end
      end
      S_HOLD: begin
        if (cnt == '0) begin
          row_done = 1'b1;
          if (!fifo_empty) begin
            state_d  = S_SETUP;
            cbitin_d = fifo_head;
            cnt_d    = SETUP_INIT;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          cnt_d = cnt - 8'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
    // Asserting blk_reset or flushing cancels the row in flight; the head
    // word stays queued so a later release resends it.
    if (abort) begin
      state_d   = S_IDLE;
      confclk_d = 1'b0;
      pop       = 1'b0;
      row_done  = 1'b0;
    end
  end

  always_comb begin
    rd_data = '0;
    case (reg_sel)
      REG_DATA:   rd_data = 32'(last_out);
      REG_CTRL:   rd_data = {31'd0, blk_reset};
      REG_STATUS: rd_data = pack_status(busy, fifo_full, fifo_empty, done,
                                        4'(fifo_level), rows);
      default:    rd_data = '0;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_n) begin
      state     <= S_IDLE;
      cnt       <= '0;
      confclk   <= 1'b0;
      cbitin    <= '0;
      blk_reset <= 1'b1;
      last_out  <= '0;
      rows      <= '0;
      wbs_ack_o <= 1'b0;
      wbs_dat_o <= '0;
    end else begin
      state     <= state_d;
      cnt       <= cnt_d;
      confclk   <= confclk_d;
      cbitin    <= cbitin_d;
      wbs_ack_o <= wb_take;
      wbs_dat_o <= (wb_take && !wbs_we_i) ? rd_data : '0;
      if (ctrl_wr) blk_reset <= wbs_dat_i[CTRL_BLK_RESET_BIT];
      if (row_done) begin
        last_out <= cbitout;
        if (rows != 8'hFF) rows <= rows + 8'd1;
      end
      if (abort) rows <= '0;
    end
  end

endmodule

// File: tb/tb_yblock_config_loader.sv
// Directed bench for yblock_config_loader: register table, then timed
// multi-cycle sequences for shifting, stalls, reset-abort and flush.
module tb_yblock_config_loader;

  localparam logic [31:0] A_DATA = 32'h3000_0000;
  localparam logic [31:0] A_CTRL = 32'h3000_0004;
  localparam logic [31:0] A_STAT = 32'h3000_0008;
  localparam logic [31:0] A_R3   = 32'h3000_000C;
  localparam logic [31:0] A_MISS = 32'h3000_0010;

  logic        wb_clk_i = 1'b0;
  logic        wb_rst_n;
  logic        wbs_stb_i, wbs_cyc_i, wbs_we_i;
  logic [3:0]  wbs_sel_i;
  logic [31:0] wbs_adr_i, wbs_dat_i;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;
  logic [15:0] cbitin;
  logic        confclk;
  logic        blk_reset;
  logic [15:0] cbitout;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  logic [15:0] exp_q[$];
  int          rise_q[$];
  logic        conf_prev = 1'b0;

  yblock_config_loader dut (
    .wb_clk_i  (wb_clk_i),
    .wb_rst_n  (wb_rst_n),
    .wbs_stb_i (wbs_stb_i),
    .wbs_cyc_i (wbs_cyc_i),
    .wbs_we_i  (wbs_we_i),
    .wbs_sel_i (wbs_sel_i),
    .wbs_adr_i (wbs_adr_i),
    .wbs_dat_i (wbs_dat_i),
    .wbs_ack_o (wbs_ack_o),
    .wbs_dat_o (wbs_dat_o),
    .cbitin    (cbitin),
    .confclk   (confclk),
    .blk_reset (blk_reset),
    .cbitout   (cbitout)
  );

  // Clock and cycle counter
  always #5 wb_clk_i = ~wb_clk_i;
  always @(posedge wb_clk_i) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Scoreboard: each confclk rise must present the next expected row word.
  always @(negedge wb_clk_i) begin
    if (confclk && !conf_prev) begin
      rise_q.push_back(cyc);
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL pulse_unexpected: got confclk rise at cycle %0d expected none", cyc);
      end else begin
        check("pulse_cbitin", 32'(cbitin), 32'(exp_q.pop_front()));
      end
    end
    conf_prev = confclk;
  end

  // Driver tasks
  task automatic wb_xfer(input logic [31:0] adr, input logic we, input logic [31:0] dat,
                         input logic [3:0] sel, input int budget,
                         output logic [31:0] rdata, output int ack_cyc,
                         output int start_cyc, output bit got);
    @(posedge wb_clk_i); #1;
    wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = we;
    wbs_adr_i = adr;  wbs_dat_i = dat;  wbs_sel_i = sel;
    start_cyc = cyc; got = 1'b0; rdata = '0; ack_cyc = 0;
    for (int i = 0; i < budget; i++) begin
      @(posedge wb_clk_i); #1;
      if (wbs_ack_o) begin
        got = 1'b1; ack_cyc = cyc; rdata = wbs_dat_o;
        break;
      end
    end
    wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_we_i = 1'b0;
  endtask

  task automatic do_wr(input string name, input logic [31:0] adr, input logic [31:0] dat,
                       output int ack_cyc);
    logic [31:0] rd; int st; bit got;
    wb_xfer(adr, 1'b1, dat, 4'hF, 50, rd, ack_cyc, st, got);
    check({name, "_ack"}, 32'(got), 32'd1);
  endtask

  task automatic do_rd(input string name, input logic [31:0] adr, input logic [31:0] exp);
    logic [31:0] rd; int st, ac; bit got;
    wb_xfer(adr, 1'b0, 32'd0, 4'hF, 50, rd, ac, st, got);
    check({name, "_ack"}, 32'(got), 32'd1);
    if (got) check(name, rd, exp);
  endtask

  task automatic wait_rises(input int n, input int budget);
    for (int k = 0; k < budget && rise_q.size() < n; k++) @(posedge wb_clk_i);
    repeat (10) @(posedge wb_clk_i);
  endtask

  typedef struct {
    logic [31:0] adr;
    logic        we;
    logic [31:0] dat;
    logic [3:0]  sel;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[13];

  initial begin
    logic [31:0] rd;
    int ack_c, st_c, t, r, first;
    bit got, stalled;
    logic [15:0] w;

    vecs[0]  = '{A_STAT, 1'b0, 32'h0,          4'hF, 32'h0000_0004};
    vecs[1]  = '{A_CTRL, 1'b0, 32'h0,          4'hF, 32'h0000_0001};
    vecs[2]  = '{A_DATA, 1'b0, 32'h0,          4'hF, 32'h0000_0000};
    vecs[3]  = '{A_R3,   1'b0, 32'h0,          4'hF, 32'h0000_0000};
    vecs[4]  = '{A_R3,   1'b1, 32'hFFFF_FFFF,  4'hF, 32'h0};
    vecs[5]  = '{A_CTRL, 1'b0, 32'h0,          4'hF, 32'h0000_0001};
    vecs[6]  = '{A_DATA, 1'b1, 32'h0000_1234,  4'h1, 32'h0};
    vecs[7]  = '{A_STAT, 1'b0, 32'h0,          4'hF, 32'h0000_0004};
    vecs[8]  = '{A_DATA, 1'b1, 32'h0000_1111,  4'h3, 32'h0};
    vecs[9]  = '{A_STAT, 1'b0, 32'h0,          4'hF, 32'h0000_0010};
    vecs[10] = '{A_CTRL, 1'b1, 32'h0000_0003,  4'hF, 32'h0};
    vecs[11] = '{A_STAT, 1'b0, 32'h0,          4'hF, 32'h0000_0004};
    vecs[12] = '{A_CTRL, 1'b0, 32'h0,          4'hF, 32'h0000_0001};

    // Reset
    wb_rst_n = 1'b0; wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_we_i = 1'b0;
    wbs_sel_i = '0; wbs_adr_i = '0; wbs_dat_i = '0; cbitout = 16'h1111;
    repeat (3) @(posedge wb_clk_i);
    @(negedge wb_clk_i);
    check("rst_ack", 32'(wbs_ack_o), 32'd0);
    check("rst_dat", wbs_dat_o, 32'd0);
    check("rst_cbitin", 32'(cbitin), 32'd0);
    check("rst_confclk", 32'(confclk), 32'd0);
    check("rst_blk_reset", 32'(blk_reset), 32'd1);
    @(posedge wb_clk_i); #1;
    wb_rst_n = 1'b1;

    // Register table (blk_reset held, so nothing shifts)
    for (int i = 0; i < 13; i++) begin
      wb_xfer(vecs[i].adr, vecs[i].we, vecs[i].dat, vecs[i].sel, 50, rd, ack_c, st_c, got);
      check($sformatf("vec%0d_ack", i), 32'(got), 32'd1);
      if (!vecs[i].we) check($sformatf("vec%0d_rd", i), rd, vecs[i].exp);
    end

    // Single row: timing of cbitin/confclk and last_out capture at end of HOLD
    do_wr("t2_ctrl", A_CTRL, 32'h0, t);
    exp_q.push_back(16'hA5A5);
    do_wr("t2_push", A_DATA, 32'h0000_A5A5, t);
    for (int k = 0; k <= 8; k++) begin
      @(negedge wb_clk_i);
      check($sformatf("t2_confclk_c%0d", cyc - t), 32'(confclk),
            ((cyc - t == 3) || (cyc - t == 4)) ? 32'd1 : 32'd0);
      if (cyc - t == 1) check("t2_cbitin", 32'(cbitin), 32'h0000_A5A5);
      if (cyc - t == 6) cbitout = 16'h5A5A;
      if (cyc - t == 7) cbitout = 16'h2222;
    end
    do_rd("t2_status", A_STAT, 32'h0000_0104);
    do_rd("t2_last_out", A_DATA, 32'h0000_5A5A);

    // Sixteen back-to-back rows with FIFO back-pressure
    do_wr("t3_flush", A_CTRL, 32'h2, t);
    rise_q.delete();
    stalled = 1'b0;
    for (int i = 0; i < 16; i++) begin
      w = 16'd1 << i;
      exp_q.push_back(w);
      wb_xfer(A_DATA, 1'b1, 32'(w), 4'hF, 50, rd, ack_c, st_c, got);
      check($sformatf("t3_push%0d_ack", i), 32'(got), 32'd1);
      if (ack_c - st_c > 1) stalled = 1'b1;
    end
    wb_xfer(A_STAT, 1'b0, 32'h0, 4'hF, 50, rd, ack_c, st_c, got);
    check("t3_status_full", {24'd0, rd[7:0]}, 32'h0000_0043);
    check("t3_stalled", 32'(stalled), 32'd1);
    wait_rises(16, 300);
    check("t3_pulses", rise_q.size(), 16);
    for (int i = 1; i < rise_q.size(); i++)
      check($sformatf("t3_spacing%0d", i), rise_q[i] - rise_q[i-1], 6);
    do_rd("t3_status_done", A_STAT, 32'h0000_100C);

    // Fifth write against a full FIFO waits for the first pop
    do_wr("t4_hold", A_CTRL, 32'h3, t);
    rise_q.delete();
    for (int i = 0; i < 4; i++) begin
      w = 16'h0F00 + 16'(i);
      exp_q.push_back(w);
      do_wr($sformatf("t4_push%0d", i), A_DATA, 32'(w), t);
    end
    do_rd("t4_status_full", A_STAT, 32'h0000_0042);
    exp_q.push_back(16'hBEEF);
    do_wr("t4_release", A_CTRL, 32'h0, r);
    wb_xfer(A_DATA, 1'b1, 32'h0000_BEEF, 4'hF, 50, rd, ack_c, st_c, got);
    check("t4_5th_ack", 32'(got), 32'd1);
    check("t4_5th_ack_cycle", ack_c - r, 6);
    wait_rises(5, 200);
    first = (rise_q.size() > 0) ? rise_q[0] : -1;
    check("t4_pulses", rise_q.size(), 5);
    check("t4_first_rise", first - r, 3);
    do_rd("t4_status_end", A_STAT, 32'h0000_0504);

    // blk_reset asserted during the second row's pulse
    do_wr("t5_hold", A_CTRL, 32'h3, t);
    rise_q.delete();
    for (int i = 0; i < 3; i++) begin
      w = 16'hC001 + 16'(i);
      exp_q.push_back(w);
      do_wr($sformatf("t5_push%0d", i), A_DATA, 32'(w), t);
    end
    do_wr("t5_release", A_CTRL, 32'h0, r);
    repeat (8) @(posedge wb_clk_i);
    wb_xfer(A_CTRL, 1'b1, 32'h1, 4'hF, 50, rd, ack_c, st_c, got);
    check("t5_abort_ack", 32'(got), 32'd1);
    check("t5_abort_cycle", ack_c - r, 10);
    @(negedge wb_clk_i);
    check("t5_confclk_low", 32'(confclk), 32'd0);
    first = (rise_q.size() > 1) ? rise_q[1] : -1;
    check("t5_rises_before", rise_q.size(), 2);
    check("t5_second_rise", first - r, 9);
    exp_q.push_front(16'hC002);
    do_rd("t5_status_abort", A_STAT, 32'h0000_0020);
    repeat (20) @(posedge wb_clk_i);
    check("t5_no_shift_in_reset", rise_q.size(), 2);
    do_wr("t5_resume", A_CTRL, 32'h0, r);
    wait_rises(4, 200);
    check("t5_rises_after", rise_q.size(), 4);
    do_rd("t5_status_end", A_STAT, 32'h0000_0204);

    // Flush with rows queued, then non-hit accesses
    do_wr("t6_hold", A_CTRL, 32'h3, t);
    rise_q.delete();
    for (int i = 0; i < 3; i++)
      do_wr($sformatf("t6_push%0d", i), A_DATA, 32'h0000_D001 + 32'(i), t);
    do_rd("t6_status_q3", A_STAT, 32'h0000_0030);
    do_wr("t6_release", A_CTRL, 32'h0, r);
    wb_xfer(A_CTRL, 1'b1, 32'h2, 4'hF, 50, rd, ack_c, st_c, got);
    check("t6_flush_ack", 32'(got), 32'd1);
    check("t6_flush_cycle", ack_c - r, 2);
    repeat (30) @(posedge wb_clk_i);
    check("t6_no_pulses", rise_q.size(), 0);
    do_rd("t6_status", A_STAT, 32'h0000_0004);

    wb_xfer(A_MISS, 1'b1, 32'h0000_7777, 4'hF, 10, rd, ack_c, st_c, got);
    check("nohit_wr_ack", 32'(got), 32'd0);
    wb_xfer(A_MISS, 1'b0, 32'h0, 4'hF, 10, rd, ack_c, st_c, got);
    check("nohit_rd_ack", 32'(got), 32'd0);
    do_rd("nohit_status", A_STAT, 32'h0000_0004);
    check("exp_q_drained", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
